irq_controller: RTL and testbench

Memory-mapped interrupt aggregator that sits directly upstream of the CPU's `interrupt_i` input and on the data memory bus alongside RAM. It synchronises up to 31 external interrupt sources, latches them as pending, masks them with a software enable register, and drives a single registered interrupt request into the CPU. Software identifies and acknowledges the highest-priority source through a claim register, read over the same data bus the memory-access stage drives.

---
 rtl/irq_controller_if.sv | 19 +
 rtl/irq_controller.sv | 120 ++++++++++++
 tb/tb_irq_controller.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Data-bus port of the interrupt controller: the memory stage is master, the controller slave.
interface irq_controller_if;
    logic        sel_i;
    logic [31:0] addr_i;
    logic        read_enable_i;
    logic [3:0]  write_mask_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;

    modport master (
        output sel_i, addr_i, read_enable_i, write_mask_i, write_data_i,
        input  read_data_o
    );

    modport slave (
        input  sel_i, addr_i, read_enable_i, write_mask_i, write_data_i,
        output read_data_o
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt aggregator: synchronised sources, PENDING/ENABLE/EDGE/CLAIM registers, registered irq_o.
// Edge-triggered sources, PENDING W1C and CLAIM clear exist only with IRQ_CONTROLLER_EDGE_EN defined.
module irq_controller #(
    parameter int unsigned SOURCES     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [SOURCES-1:0] irq_i,
    irq_controller_if.slave    bus,
    output logic               irq_o
);
    logic [SOURCES-1:0] r_sync [SYNC_STAGES];
    logic [SOURCES-1:0] r_enable;
    logic [31:0]        r_read_data;
    logic               r_irq;

    logic [31:0]        w_lane_mask;
    logic [SOURCES-1:0] w_src_mask;
    logic [SOURCES-1:0] w_wdata;
    logic [SOURCES-1:0] w_sync;
    logic [SOURCES-1:0] w_pending;
    logic [SOURCES-1:0] w_active;
    logic [SOURCES-1:0] w_edge;
    logic [4:0]         w_claim_id;
    logic [31:0]        w_read_mux;
    logic [1:0]         w_reg;
    logic               w_rd;
    logic               w_wr;
    logic               w_unused;

    assign w_reg       = bus.addr_i[3:2];
    assign w_rd        = bus.sel_i && bus.read_enable_i;
    assign w_wr        = bus.sel_i && (bus.write_mask_i != 4'b0000);
    assign w_lane_mask = {{8{bus.write_mask_i[3]}}, {8{bus.write_mask_i[2]}},
                          {8{bus.write_mask_i[1]}}, {8{bus.write_mask_i[0]}}};
    assign w_src_mask  = w_lane_mask[SOURCES-1:0];
    assign w_wdata     = bus.write_data_i[SOURCES-1:0];
    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_active    = w_pending & r_enable;
    assign w_unused    = &{1'b0, bus.addr_i, bus.write_data_i, w_lane_mask};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= irq_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

`ifdef IRQ_CONTROLLER_EDGE_EN
    logic [SOURCES-1:0] r_edge;
    logic [SOURCES-1:0] r_edge_pend;
    logic [SOURCES-1:0] r_prev;
    logic [SOURCES-1:0] w_rise;
    logic [SOURCES-1:0] w_claim_hot;
    logic [SOURCES-1:0] w_clear;

    assign w_rise    = w_sync & ~r_prev;
    assign w_edge    = r_edge;
    assign w_pending = (r_edge & r_edge_pend) | (~r_edge & w_sync);

    always_comb begin
        w_claim_hot = '0;
        for (int unsigned i = 0; i < SOURCES; i++) w_claim_hot[i] = (w_claim_id == 5'(i + 1));
        w_clear = '0;
        if (w_rd && (w_reg == 2'd3)) w_clear = w_claim_hot;
        if (w_wr && (w_reg == 2'd0)) w_clear = w_clear | (w_wdata & w_src_mask);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_edge      <= '0;
            r_edge_pend <= '0;
            r_prev      <= '0;
        end else begin
            r_prev <= w_sync;
            // level bits keep tracking their input here so an EDGE 0->1 change preserves pending
            r_edge_pend <= (r_edge & ((r_edge_pend & ~w_clear) | w_rise)) | (~r_edge & w_sync);
            if (w_wr && (w_reg == 2'd2)) r_edge <= (r_edge & ~w_src_mask) | (w_wdata & w_src_mask);
        end
    end
`else
    assign w_edge    = '0;
    assign w_pending = w_sync;
`endif

    always_comb begin
        w_claim_id = '0;
        for (int unsigned i = SOURCES; i > 0; i--) begin
            if (w_active[i-1]) w_claim_id = 5'(i);
        end
    end

    always_comb begin
        w_read_mux = '0;
        case (w_reg)
            2'd0:    w_read_mux = 32'(w_pending);
            2'd1:    w_read_mux = 32'(r_enable);
            2'd2:    w_read_mux = 32'(w_edge);
            default: w_read_mux = 32'(w_claim_id);
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_enable    <= '0;
            r_read_data <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr && (w_reg == 2'd1)) r_enable <= (r_enable & ~w_src_mask) | (w_wdata & w_src_mask);
            if (w_rd) r_read_data <= w_read_mux;
            r_irq <= |w_active;
        end
    end

    assign bus.read_data_o = r_read_data;
    assign irq_o           = r_irq;
endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller against a per-source behavioural model.
module tb_irq_controller;
    localparam int unsigned SOURCES     = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [31:0] SRC_MASK    = 32'((64'd1 << SOURCES) - 64'd1);
`ifdef IRQ_CONTROLLER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic               clk;
    logic               reset_ni;
    logic [SOURCES-1:0] irq_i;
    logic               irq_o;
    irq_controller_if   bus_if ();

    irq_controller #(.SOURCES(SOURCES), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i   (clk),
        .reset_ni(reset_ni),
        .irq_i   (irq_i),
        .bus     (bus_if),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [31:0] rd_val;

    logic [31:0] m_sync_q[$];
    logic [31:0] m_prev, m_pend, m_en, m_edge, m_rd;
    logic        m_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sync_q = {};
        for (int i = 0; i < int'(SYNC_STAGES); i++) m_sync_q.push_back(32'h0);
        m_prev = '0; m_pend = '0; m_en = '0; m_edge = '0; m_rd = '0; m_irq = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] act, clr, cur_sync, new_sync, rise, new_edge, np, wmask;
        logic [1:0]  idx;
        int          claim;
        bit          is_rd, is_wr;
        if (!reset_ni) begin
            model_reset();
            return;
        end
        act   = m_pend & m_en;
        claim = 0;
        for (int i = int'(SOURCES) - 1; i >= 0; i--) if (act[i]) claim = i + 1;
        cur_sync = m_sync_q[0];
        m_sync_q.push_back(32'(irq_i));
        void'(m_sync_q.pop_front());
        new_sync = m_sync_q[0];
        rise   = cur_sync & ~m_prev;
        m_prev = cur_sync;
        wmask  = {{8{bus_if.write_mask_i[3]}}, {8{bus_if.write_mask_i[2]}},
                  {8{bus_if.write_mask_i[1]}}, {8{bus_if.write_mask_i[0]}}};
        is_rd  = bus_if.sel_i && bus_if.read_enable_i;
        is_wr  = bus_if.sel_i && (bus_if.write_mask_i != 4'h0);
        idx    = bus_if.addr_i[3:2];
        clr    = '0;
        new_edge = m_edge;
        if (is_rd) begin
            case (idx)
                2'd0: m_rd = m_pend;
                2'd1: m_rd = m_en;
                2'd2: m_rd = m_edge;
                default: begin
                    m_rd = 32'(claim);
                    if (claim != 0 && EDGE_EN) clr[claim-1] = 1'b1;
                end
            endcase
        end
        if (is_wr) begin
            case (idx)
                2'd0: if (EDGE_EN) clr = clr | (bus_if.write_data_i & wmask);
                2'd1: m_en = ((m_en & ~wmask) | (bus_if.write_data_i & wmask)) & SRC_MASK;
                2'd2: if (EDGE_EN) new_edge = ((m_edge & ~wmask) | (bus_if.write_data_i & wmask)) & SRC_MASK;
                default: ;
            endcase
        end
        np = '0;
        for (int i = 0; i < int'(SOURCES); i++) begin
            if (!new_edge[i])     np[i] = new_sync[i];
            else if (!m_edge[i])  np[i] = m_pend[i];
            else if (rise[i])     np[i] = 1'b1;
            else                  np[i] = m_pend[i] && !clr[i];
        end
        m_irq  = (act != 0);
        m_pend = np;
        m_edge = new_edge;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("irq_o", 32'(irq_o), 32'(m_irq));
        check("read_data_o", bus_if.read_data_o, m_rd);
    endtask

    task automatic idle_bus();
        bus_if.sel_i = 1'b0; bus_if.read_enable_i = 1'b0; bus_if.write_mask_i = 4'h0;
        bus_if.addr_i = '0; bus_if.write_data_i = '0;
    endtask

    task automatic bus_write(input logic [1:0] r, input logic [3:0] m, input logic [31:0] d);
        bus_if.sel_i = 1'b1; bus_if.read_enable_i = 1'b0; bus_if.write_mask_i = m;
        bus_if.addr_i = {28'h0, r, 2'b00}; bus_if.write_data_i = d;
        step();
        idle_bus();
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        bus_if.sel_i = 1'b1; bus_if.read_enable_i = 1'b1; bus_if.write_mask_i = 4'h0;
        bus_if.addr_i = {28'h0, r, 2'b00}; bus_if.write_data_i = '0;
        step();
        d = bus_if.read_data_o;
        idle_bus();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [1:0]  ri;
        int unsigned op;
        clk = 1'b0; reset_ni = 1'b0; irq_i = '0; checks = 0; errors = 0;
        idle_bus();
        model_reset();
        wait_cycles(2);
        reset_ni = 1'b1;
        wait_cycles(1);

        // reset values
        check("reset irq_o", 32'(irq_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), rd_val);
            check($sformatf("reset reg%0d", i), rd_val, 32'h0);
        end

        // level source 2
        bus_write(2'd1, 4'hF, 32'h05);
        irq_i = 8'h04;
        wait_cycles(2);
        bus_read(2'd0, rd_val);
        check("level pending", rd_val, 32'h04);
        check("level irq_o", 32'(irq_o), 32'h1);
        bus_read(2'd3, rd_val);
        check("level claim", rd_val, 32'h3);
        bus_read(2'd0, rd_val);
        check("level claim no clear", rd_val, 32'h04);
        irq_i = 8'h00;
        wait_cycles(2);
        check("level drop irq_o still high", 32'(irq_o), 32'h1);
        wait_cycles(1);
        check("level drop irq_o low", 32'(irq_o), 32'h0);

        // edge sources 0 and 1
        bus_write(2'd2, 4'hF, 32'h03);
        bus_write(2'd1, 4'hF, 32'h03);
        irq_i = 8'h01; step();
        irq_i = 8'h02; step();
        irq_i = 8'h00;
        wait_cycles(4);
        bus_read(2'd0, rd_val);
        if (EDGE_EN) check("edge pending", rd_val, 32'h03);
        bus_read(2'd3, rd_val);
        if (EDGE_EN) check("edge claim 1", rd_val, 32'h1);
        bus_read(2'd3, rd_val);
        if (EDGE_EN) check("edge claim 2", rd_val, 32'h2);
        if (EDGE_EN) check("edge irq_o after claim 2", 32'(irq_o), 32'h1);
        bus_read(2'd3, rd_val);
        check("edge claim empty", rd_val, 32'h0);
        check("edge irq_o after claims", 32'(irq_o), 32'h0);

        // W1C racing a new rising edge on source 1
        irq_i = 8'h02; step();
        irq_i = 8'h00;
        wait_cycles(4);
        bus_read(2'd0, rd_val);
        if (EDGE_EN) check("edge 1 held pending", rd_val & 32'h2, 32'h2);
        irq_i = 8'h02;
        wait_cycles(2);
        bus_write(2'd0, 4'hF, 32'h02);
        bus_read(2'd0, rd_val);
        check("w1c race set wins", rd_val & 32'h2, 32'h2);
        irq_i = 8'h00;
        wait_cycles(3);
        bus_write(2'd0, 4'hF, 32'h02);
        bus_read(2'd0, rd_val);
        check("w1c clears", rd_val & 32'h2, 32'h0);

        // asynchronous reset during a claim read
        bus_write(2'd1, 4'hF, 32'h11);
        irq_i = 8'h11;
        wait_cycles(3);
        bus_if.sel_i = 1'b1; bus_if.read_enable_i = 1'b1; bus_if.addr_i = 32'hC;
        #2;
        reset_ni = 1'b0;
        #1;
        model_reset();
        check("async reset irq_o", 32'(irq_o), 32'h0);
        check("async reset read_data_o", bus_if.read_data_o, 32'h0);
        wait_cycles(3);
        reset_ni = 1'b1;
        idle_bus();
        bus_write(2'd1, 4'hF, 32'h11);
        wait_cycles(SYNC_STAGES + 1);
        bus_read(2'd3, rd_val);
        check("post reset claim", rd_val, 32'h1);

        // byte lane holding only unimplemented bits
        bus_write(2'd1, 4'hF, 32'h0);
        bus_write(2'd1, 4'h2, 32'hFFFF_FFFF);
        bus_read(2'd1, rd_val);
        check("lane1 enable write", rd_val, 32'h0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            if ((r & 32'h3) == 0) begin
                r = $urandom;
                irq_i = r[SOURCES-1:0];
            end
            op = $urandom_range(0, 3);
            r  = $urandom;
            ri = r[3:2];
            bus_if.sel_i         = ($urandom_range(0, 7) != 0);
            bus_if.addr_i        = {r[31:4], ri, r[1:0]};
            bus_if.read_enable_i = (op == 2);
            r = $urandom;
            bus_if.write_mask_i  = (op == 3) ? r[3:0] : 4'h0;
            bus_if.write_data_i  = $urandom;
            step();
            idle_bus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
